// File: rtl/riscv_lsu_mem_adapter.sv
// Load/store adapter: steers byte/half/word/dword accesses onto
// aligned memory beats, splitting boundary crossers into two beats.
module riscv_lsu_mem_adapter #(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 32,
  parameter int STRB_WIDTH  = DATA_WIDTH/8,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [2:0]            i_req_width,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic                  o_mem_valid,
  input  logic                  i_mem_ready,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic [STRB_WIDTH-1:0] o_mem_strb,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  localparam int DW   = DATA_WIDTH;
  localparam int SW   = STRB_WIDTH;
  localparam int OFFW = $clog2(STRB_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    BEAT0,
    WAIT0,
    BEAT1,
    WAIT1,
    RESP
  } state_t;

  state_t          state;
  logic            we_q;
  logic            uns_q;
  logic            cross_q;
  logic [1:0]      size_q;
  logic [OFFW-1:0] off_q;
  logic [DW-1:0]   hi_wdata_q;
  logic [SW-1:0]   hi_strb_q;
  logic [DW-1:0]   half0_q;

  logic [OFFW-1:0]       req_off;
  logic [3:0]            req_nb;
  logic [4:0]            req_end;
  logic                  req_cross;
  logic                  req_bad;
  logic [SW-1:0]         req_lmask;
  logic [DW-1:0]         req_data;
  logic [2*DW-1:0]       req_wvec;
  logic [2*SW-1:0]       req_mask;
  logic [ADDR_WIDTH-1:0] req_addr0;

  always_comb begin
    req_off   = i_req_addr[OFFW-1:0];
    req_nb    = 4'd1 << i_req_width[1:0];
    req_end   = 5'(req_off) + 5'(req_nb);
    req_cross = req_end > 5'(SW);
    req_bad   = (i_req_width[1:0] == 2'd3 && DW == 32)
             || (req_cross && !MISALIGN_EN);
    for (int i = 0; i < SW; i++) begin
      req_lmask[i] = 4'(i) < req_nb;
      req_data[8*i +: 8] = req_lmask[i] ?
        i_req_wdata[8*i +: 8] : 8'h00;
    end
    // Two-beat window: low half goes out first, high half second.
    req_wvec  = {{DW{1'b0}}, req_data} << {req_off, 3'b000};
    req_mask  = {{SW{1'b0}}, req_lmask} << req_off;
    req_addr0 = {i_req_addr[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
  end

  logic [3:0]      nb;
  logic [2*DW-1:0] ld_pair;
  logic [DW-1:0]   ld_raw;
  logic [DW-1:0]   ld_data;
  logic            ld_sign;

  always_comb begin
    nb      = 4'd1 << size_q;
    ld_pair = (state == WAIT1) ? {i_mem_rdata, half0_q}
                               : {{DW{1'b0}}, i_mem_rdata};
    ld_raw  = DW'(ld_pair >> {off_q, 3'b000});
    case (size_q)
      2'd0:    ld_sign = ld_raw[7];
      2'd1:    ld_sign = ld_raw[15];
      2'd2:    ld_sign = ld_raw[31];
      default: ld_sign = 1'b0;
    endcase
    ld_sign = ld_sign & ~uns_q;
    for (int i = 0; i < SW; i++) begin
      ld_data[8*i +: 8] = (4'(i) < nb) ?
        ld_raw[8*i +: 8] : {8{ld_sign}};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      o_req_ready <= 1'b1;
      o_rsp_valid <= 1'b0;
      o_rsp_err   <= 1'b0;
      o_rsp_rdata <= '0;
      o_mem_valid <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_strb  <= '0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      cross_q     <= 1'b0;
      size_q      <= '0;
      off_q       <= '0;
      hi_wdata_q  <= '0;
      hi_strb_q   <= '0;
      half0_q     <= '0;
    end else begin
      o_rsp_valid <= 1'b0;
      o_rsp_err   <= 1'b0;
      o_rsp_rdata <= '0;
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            o_req_ready <= 1'b0;
            we_q        <= i_req_we;
            uns_q       <= i_req_width[2];
            size_q      <= i_req_width[1:0];
            off_q       <= req_off;
            cross_q     <= req_cross;
            if (req_bad) begin
              state       <= RESP;
              o_rsp_valid <= 1'b1;
              o_rsp_err   <= 1'b1;
            end else begin
              state       <= BEAT0;
              o_mem_valid <= 1'b1;
              o_mem_we    <= i_req_we;
              o_mem_addr  <= req_addr0;
              o_mem_wdata <= i_req_we ? req_wvec[DW-1:0] : '0;
              o_mem_strb  <= req_mask[SW-1:0];
              hi_wdata_q  <= i_req_we ? req_wvec[2*DW-1:DW] : '0;
              hi_strb_q   <= req_mask[2*SW-1:SW];
            end
          end
        end
        BEAT0: begin
          if (i_mem_ready) begin
            if (we_q && cross_q) begin
              state       <= BEAT1;
              o_mem_addr  <= o_mem_addr + ADDR_WIDTH'(SW);
              o_mem_wdata <= hi_wdata_q;
              o_mem_strb  <= hi_strb_q;
            end else if (we_q) begin
              state       <= RESP;
              o_mem_valid <= 1'b0;
              o_rsp_valid <= 1'b1;
            end else begin
              state       <= WAIT0;
              o_mem_valid <= 1'b0;
            end
          end
        end
        WAIT0: begin
          if (i_mem_rvalid) begin
            half0_q <= i_mem_rdata;
            if (cross_q) begin
              state       <= BEAT1;
              o_mem_valid <= 1'b1;
              o_mem_addr  <= o_mem_addr + ADDR_WIDTH'(SW);
              o_mem_strb  <= hi_strb_q;
            end else begin
              state       <= RESP;
              o_rsp_valid <= 1'b1;
              o_rsp_rdata <= ld_data;
            end
          end
        end
        BEAT1: begin
          if (i_mem_ready) begin
            o_mem_valid <= 1'b0;
            if (we_q) begin
              state       <= RESP;
              o_rsp_valid <= 1'b1;
            end else begin
              state <= WAIT1;
            end
          end
        end
        WAIT1: begin
          if (i_mem_rvalid) begin
            state       <= RESP;
            o_rsp_valid <= 1'b1;
            o_rsp_rdata <= ld_data;
          end
        end
        RESP: begin
          state       <= IDLE;
          o_req_ready <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          o_req_ready <= 1'b1;
          o_mem_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
